fir_output_collector: RTL and testbench

- Receive-side companion of the 6-tap transposed FIR filter.
- Tracks which filter outputs carry valid samples, rounds and saturates the 26-bit result `b` down to a 16-bit sample, and buffers the samples in a small FIFO.
- Presents the samples downstream on a valid/ready handshake.
- Sits directly after the filter in the datapath; its `in_valid` is driven by whoever drives the filter input `a`.

---
 rtl/fir_output_collector.sv | 173 +++++++++++++++++
 tb/tb_fir_output_collector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_collector.sv
// fir_output_collector: receive side of the 6-tap transposed FIR filter.
// Lines up the valid flag with the filter output b, rounds b down to an
// OUT_W-bit sample and buffers the samples in a DEPTH-entry FIFO. The FIFO
// drives a valid/ready interface downstream.
//
// Optional feature: define FIR_COLL_SAT_EN to saturate the rounded sample to
// the OUT_W range. When it is undefined, the sample keeps only its low OUT_W
// bits (two's-complement wrap) and no saturation logic is built.
//
// Handshake: a sample transfers in any cycle where out_valid and out_ready are
// both high. out_valid never depends on out_ready. out_data holds steady while
// out_valid is high and out_ready is low.
module fir_output_collector #(
    parameter int IN_W    = 26,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [IN_W-1:0]              b,
    input  logic                         flush,
    input  logic                         clr_ovf,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Rounding constant 2^(SHIFT-1), at IN_W+1 bits so that b + RND cannot overflow
    localparam logic signed [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

    // Valid pipeline that tracks the filter latency
    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic               aligned_valid;

    // Rounding stage
    logic                    r_valid_q, r_valid_d;
    logic [OUT_W-1:0]        r_data_q, r_data_d;
    logic signed [IN_W:0]    b_ext;
    logic signed [IN_W:0]    sum_w;
    logic signed [IN_W:0]    t_w;

    // FIFO
    logic [OUT_W-1:0]        mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    full_w;
    logic                    push_w;
    logic                    pop_w;
    logic                    drop_w;

    assign aligned_valid = vpipe_q[LATENCY-1];

    // Shift in_valid through LATENCY stages; flush empties the pipeline
    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = in_valid;
        for (int i = 1; i < LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
        if (flush) begin
            vpipe_d = '0;
        end
    end

    // Round half up with an arithmetic right shift, then fit the result to OUT_W bits
    always_comb begin
        b_ext = {b[IN_W-1], b};
        sum_w = b_ext + RND;
        t_w   = sum_w >>> SHIFT;
        r_valid_d = aligned_valid & ~flush;
        r_data_d  = r_data_q;
        if (aligned_valid) begin
`ifdef FIR_COLL_SAT_EN
            if (t_w > $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}})) begin
                r_data_d = {1'b0, {(OUT_W-1){1'b1}}};
            end else if (t_w < $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}})) begin
                r_data_d = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                r_data_d = t_w[OUT_W-1:0];
            end
`else
            r_data_d = t_w[OUT_W-1:0];
`endif
        end
    end

`ifndef FIR_COLL_SAT_EN
    // The wrap build discards the upper bits of the rounded value
    logic unused_t_hi;
    assign unused_t_hi = ^t_w[IN_W:OUT_W];
`endif

    assign full_w    = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop_w     = out_valid & out_ready;
    assign push_w    = r_valid_q & (~full_w | pop_w) & ~flush;
    assign drop_w    = r_valid_q & full_w & ~pop_w & ~flush;

    // Update the FIFO pointers, occupancy and sticky overflow; flush overrides push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_w && !pop_w) begin
                count_d = count_q + 1'b1;
            end else if (pop_w && !push_w) begin
                count_d = count_q - 1'b1;
            end
        end
        // A new drop in the same cycle as clr_ovf leaves ovf set
        if (drop_w) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vpipe_q   <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            vpipe_q   <= vpipe_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage; the contents are invalid until written, so this block has no reset
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= r_data_q;
        end
    end

    // An empty FIFO presents zero rather than a stale entry
    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_fir_output_collector.sv
// Self-checking bench for fir_output_collector. A two-stage delay line stands in
// for the filter: each value written to a_val appears on b two cycles later,
// aligned with the collector's valid pipeline.
module tb_fir_output_collector;

    localparam int IN_W  = 26;
    localparam int OUT_W = 16;

    typedef struct {
        logic [IN_W-1:0]  b;
        logic [OUT_W-1:0] exp;
        string            name;
    } vec_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             flush     = 1'b0;
    logic             clr_ovf   = 1'b0;
    logic             out_ready = 1'b0;
    logic [IN_W-1:0]  a_val     = '0;
    logic [IN_W-1:0]  a_d1      = '0;
    logic [IN_W-1:0]  b_drv     = '0;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic [2:0]       count;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[7];

    fir_output_collector dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .b         (b_drv),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Advance one cycle and move the filter delay line forward
    task automatic tick();
        @(posedge clk);
        #1;
        b_drv = a_d1;
        a_d1  = a_val;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One-cycle in_valid pulse with the matching b value
    task automatic send(input logic [IN_W-1:0] v);
        in_valid = 1'b1;
        a_val    = v;
        tick();
        in_valid = 1'b0;
    endtask

    // Back-to-back samples b = k*1024, so each rounds to k
    task automatic stream(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            in_valid = 1'b1;
            a_val    = IN_W'(k * 1024);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{IN_W'(1024), 16'h0001, "b_1024"};
        vecs[1] = '{IN_W'(512),  16'h0001, "round_512"};
        vecs[2] = '{IN_W'(511),  16'h0000, "round_511"};
        vecs[3] = '{IN_W'(-512), 16'h0000, "round_m512"};
        vecs[4] = '{IN_W'(-513), 16'hFFFF, "round_m513"};
`ifdef FIR_COLL_SAT_EN
        vecs[5] = '{26'h1FFFFFF, 16'h7FFF, "sat_max"};
`else
        vecs[5] = '{26'h1FFFFFF, 16'h8000, "wrap_max"};
`endif
        vecs[6] = '{26'h2000000, 16'h8000, "min_neg"};

        // Reset state
        #12;
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single samples: latency, rounding, saturation/wrap, pop
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].b);
            tick();
            tick();
            check({vecs[i].name, "_no_fallthru"}, 32'(out_valid), 32'd0);
            tick();
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            check({vecs[i].name, "_data"}, 32'(out_data), 32'(vecs[i].exp));
            check({vecs[i].name, "_count"}, 32'(count), 32'd1);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({vecs[i].name, "_count_after_pop"}, 32'(count), 32'd0);
            check({vecs[i].name, "_valid_after_pop"}, 32'(out_valid), 32'd0);
        end

        // Backpressure: six samples into a four-entry FIFO
        stream(1, 6);
        repeat (6) tick();
        check("bp_count_full", 32'(count), 32'd4);
        check("bp_ovf_set", 32'(ovf), 32'd1);
        check("bp_head_stable", 32'(out_data), 32'd1);
        tick();
        check("bp_head_hold", 32'(out_data), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("bp_pop_%0d", k), 32'(out_data), 32'(k));
            tick();
        end
        out_ready = 1'b0;
        check("bp_drained", 32'(count), 32'd0);
        check("bp_ovf_sticky", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("bp_ovf_cleared", 32'(ovf), 32'd0);

        // Full FIFO with push and pop in the same cycle
        stream(10, 4);
        repeat (5) tick();
        check("pp_count_full", 32'(count), 32'd4);
        send(IN_W'(14 * 1024));
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_count_kept", 32'(count), 32'd4);
        check("pp_no_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            check($sformatf("pp_pop_%0d", k), 32'(out_data), 32'(k));
            tick();
        end
        out_ready = 1'b0;
        check("pp_drained", 32'(count), 32'd0);

        // Flush with three samples buffered and two in the valid pipeline
        stream(20, 3);
        repeat (4) tick();
        check("fl_count_pre", 32'(count), 32'd3);
        stream(23, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("fl_quiet_%0d", k), 32'(out_valid), 32'd0);
        end
        check("fl_count_late", 32'(count), 32'd0);

        // Asynchronous reset between clock edges, with ovf set
        stream(30, 6);
        repeat (6) tick();
        check("ar_count_pre", 32'(count), 32'd4);
        check("ar_ovf_pre", 32'(ovf), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_ovf", 32'(ovf), 32'd0);
        #2;
        rst_n = 1'b1;
        repeat (6) tick();
        check("ar_count_after", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
